// File: rtl/mem_pkg.sv
// Shared types and constants for the word-addressed memory port unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

    localparam int WORD_SIZE = 16;
    localparam int CNT_WIDTH = 4;   // wide enough for LATENCY-1 with LATENCY up to 15

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_port_unit_if.sv
// CPU <-> memory request bus: level read/write requests, word address, completion and error status.
// Latency: n/a (wires only).
// Backpressure: CPU holds readM/writeM until mem_ready is seen.
// Ports: readM, writeM, address (CPU -> memory); mem_ready, mem_err (memory -> CPU);
//        read_count, write_count (memory -> CPU, only when MEM_STATS_EN is defined).
// The bidirectional data bus is a plain inout on the memory block, not part of this interface.
interface mem_port_unit_if;
    import mem_pkg::*;

    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;
    logic                 mem_ready;
    logic                 mem_err;
`ifdef MEM_STATS_EN
    logic [15:0]          read_count;
    logic [15:0]          write_count;
`endif

`ifdef MEM_STATS_EN
    modport master (output readM, writeM, address,
                    input  mem_ready, mem_err, read_count, write_count);
    modport slave  (input  readM, writeM, address,
                    output mem_ready, mem_err, read_count, write_count);
`else
    modport master (output readM, writeM, address,
                    input  mem_ready, mem_err);
    modport slave  (input  readM, writeM, address,
                    output mem_ready, mem_err);
`endif

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 16-bit words, write-enable, registered read.
// Latency: write commits and read data registers on the enabled posedge.
// Backpressure: none; accepts an access on any cycle en is high.
// Ports: clk, en (access strobe), we (1=write, 0=read), addr, wdata, rdata (registered).
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_SIZE-1:0]  wdata,
    output logic [WORD_SIZE-1:0]  rdata
);

    logic [WORD_SIZE-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Contents are deliberately never cleared: reset only affects the control path.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_port_unit.sv
// Word-addressed 16-bit memory for the multi-cycle CPU with fixed access latency (IDLE->BUSY->DONE FSM).
// Latency: mem_ready rises LATENCY posedges after the request is sampled in IDLE.
// Backpressure: requests are levels held by the CPU; dropping one before DONE aborts the access.
// Ports: clk, reset_n (sync, active-low), bus (mem_port_unit_if.slave: readM, writeM, address,
//        mem_ready, mem_err[, read_count, write_count]), data (shared 16-bit bidirectional bus).
// Optional feature: MEM_STATS_EN adds saturating read/write completion counters.
module mem_port_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_port_unit_if.slave       bus,
    inout  wire  [WORD_SIZE-1:0] data
);

    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(LATENCY - 1);

    state_t                state;
    state_t                next_state;
    logic [CNT_WIDTH-1:0]  cnt;
    op_t                   op;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_SIZE-1:0]  wdata_q;
    logic [WORD_SIZE-1:0]  rdata;
    logic                  err_q;
    logic                  req;
    logic                  start;
    logic                  collide;
    logic                  access_en;
    logic                  drive_rd;

    // Address bits above the array index wrap and are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.address[WORD_SIZE-1:ADDR_WIDTH];

    // Only the request line of the latched operation keeps an access alive.
    assign req     = (op == OP_WRITE) ? bus.writeM : bus.readM;
    assign start   = bus.readM ^ bus.writeM;
    assign collide = bus.readM & bus.writeM;

    // The array is touched only on the edge that enters DONE; gating with reset_n
    // keeps a reset on that same edge from committing a write.
    assign access_en = reset_n && (state == BUSY) && req && (cnt == '0);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = BUSY;
            BUSY: begin
                if (!req)              next_state = IDLE;
                else if (cnt == '0)    next_state = DONE;
            end
            DONE: if (!req) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= OP_READ;
            err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                if (start) begin
                    op     <= bus.writeM ? OP_WRITE : OP_READ;
                    addr_q <= bus.address[ADDR_WIDTH-1:0];
                    cnt    <= CNT_INIT;
                    if (bus.writeM) begin
                        wdata_q <= data;
                    end
                end
                if (collide) begin
                    err_q <= 1'b1;
                end
            end else if (state == BUSY && req && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .en    (access_en),
        .we    (op == OP_WRITE),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    // Drive enable is combinational so the bus is released as soon as readM drops.
    assign drive_rd      = (state == DONE) && (op == OP_READ) && bus.readM;
    assign data          = drive_rd ? rdata : {WORD_SIZE{1'bz}};
    assign bus.mem_ready = (state == DONE);
    assign bus.mem_err   = err_q;

`ifdef MEM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (access_en) begin
            if (op == OP_WRITE) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign bus.read_count  = rd_cnt_q;
    assign bus.write_count = wr_cnt_q;
`endif

endmodule
